// File: rtl/ser_pkg.sv
// Types and constants shared by the serializer, deserializer and word queue.
package ser_pkg;

    localparam int SER_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serializer_if.sv
// Queue handshake plus serial pins of the serializer. The serializer itself takes the master side.
interface serializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_valid_in;
    logic                  data_ack_out;
    logic                  status_in;
    logic                  data_out;
    logic                  write_out;
    logic                  busy_out;
    logic                  word_done;

    modport master (
        input  data_in, data_valid_in, status_in,
        output data_ack_out, data_out, write_out, busy_out, word_done
    );

    modport slave (
        output data_in, data_valid_in, status_in,
        input  data_ack_out, data_out, write_out, busy_out, word_done
    );
endinterface

// File: rtl/serializer.sv
// Pops one word from the queue and shifts it out MSB first, one bit per strobe,
// pausing whenever the receiver deasserts status_in.
module serializer
    import ser_pkg::*;
#(
    parameter int DATA_WIDTH = SER_DATA_WIDTH
) (
    input  logic          clock_100KHZ,
    input  logic          reset,
    serializer_if.master  bus
);
    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] sreg, sreg_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic                  ack, ack_nxt;
    logic                  dout, dout_nxt;
    logic                  wr, wr_nxt;
    logic                  busy, busy_nxt;
    logic                  done, done_nxt;

    always_ff @(posedge clock_100KHZ or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
            ack   <= 1'b0;
            dout  <= 1'b0;
            wr    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            sreg  <= sreg_nxt;
            cnt   <= cnt_nxt;
            ack   <= ack_nxt;
            dout  <= dout_nxt;
            wr    <= wr_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    // Pulses (ack, strobe, done) default low; data_out and the datapath hold.
    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        cnt_nxt   = cnt;
        ack_nxt   = 1'b0;
        dout_nxt  = dout;
        wr_nxt    = 1'b0;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.data_valid_in) begin
                    sreg_nxt  = bus.data_in;
                    ack_nxt   = 1'b1;
                    busy_nxt  = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.status_in) begin
                    dout_nxt = sreg[DATA_WIDTH-1];
                    wr_nxt   = 1'b1;
                    sreg_nxt = sreg << 1;
                    cnt_nxt  = cnt + 1'b1;
                    if (cnt == LAST) state_nxt = DONE;
                end
            end
            DONE: begin
                // Extra idle cycle lets the receiver's registered status drop.
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.data_ack_out = ack;
    assign bus.data_out     = dout;
    assign bus.write_out    = wr;
    assign bus.busy_out     = busy;
    assign bus.word_done    = done;

endmodule

// File: tb/tb_serializer.sv
// Directed bench for serializer: stimulus pushes expected words, monitors reassemble
// the serial stream (and a loopback receiver's words) and compare.
module tb_serializer;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic st = 1'b0;
    logic rx_en = 1'b0;
    always #5 clk = ~clk;

    serializer_if #(.DATA_WIDTH(DW)) bus ();
    serializer #(.DATA_WIDTH(DW)) dut (
        .clock_100KHZ(clk),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int strobes = 0;
    int acks = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_rx[$];

    // Simple model of the deserializer: registered status, ready after DW bits, acked one cycle later.
    logic          rx_status, rx_ready, rx_ack;
    logic [3:0]    rx_cnt;
    logic [DW-1:0] rx_sreg, rx_word;

    assign bus.status_in = rx_en ? rx_status : st;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_status <= 1'b1;
            rx_ready  <= 1'b0;
            rx_ack    <= 1'b0;
            rx_cnt    <= '0;
            rx_sreg   <= '0;
            rx_word   <= '0;
        end else begin
            rx_ack <= rx_ready && !rx_ack;
            if (rx_ack) begin
                rx_ready  <= 1'b0;
                rx_status <= 1'b1;
                rx_cnt    <= '0;
            end else if (rx_en && bus.write_out) begin
                rx_sreg <= {rx_sreg[DW-2:0], bus.data_out};
                rx_cnt  <= rx_cnt + 1'b1;
                if (rx_cnt == 4'(DW - 1)) begin
                    rx_ready  <= 1'b1;
                    rx_status <= 1'b0;
                    rx_word   <= {rx_sreg[DW-2:0], bus.data_out};
                end
            end
        end
    end

    // Serial monitor
    int            nbits = 0;
    logic [DW-1:0] bits = '0;
    int            last_strobe = 0;
    int            done_cyc = -100;
    logic [DW-1:0] e;
    always @(negedge clk) begin
        if (reset) begin
            nbits = 0;
        end else begin
            if (bus.data_ack_out) acks++;
            if (rx_en && bus.write_out && !rx_status) chk("rx_overrun", 1, 0);
            if (rx_en && rx_ready && !rx_ack) begin
                if (exp_rx.size() == 0) chk("rx_unexpected", 1, 0);
                else begin
                    e = exp_rx.pop_front();
                    chk("rx_word", int'(rx_word), int'(e));
                end
            end
            if (bus.word_done) begin
                chk("done_timing", cyc - last_strobe, 1);
                done_cyc = cyc;
            end
            if (bus.write_out) begin
                if (nbits == 0) chk("gap_ok", int'(cyc - done_cyc >= 2), 1);
                strobes++;
                last_strobe = cyc;
                bits = {bits[DW-2:0], bus.data_out};
                nbits++;
                if (nbits == DW) begin
                    nbits = 0;
                    if (exp_q.size() == 0) chk("word_unexpected", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("word_bits", int'(bits), int'(e));
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input string name);
        int n = 0;
        do begin step(); n++; end while (!bus.data_ack_out && n < 50);
        chk(name, int'(bus.data_ack_out), 1);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        do begin step(); n++; end while (!bus.word_done && n < 200);
        chk(name, int'(bus.word_done), 1);
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, "_ack"},  int'(bus.data_ack_out), 0);
        chk({name, "_dout"}, int'(bus.data_out), 0);
        chk({name, "_wr"},   int'(bus.write_out), 0);
        chk({name, "_busy"}, int'(bus.busy_out), 0);
        chk({name, "_done"}, int'(bus.word_done), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
    endtask

    int s0, a0;

    initial begin
        bus.data_in = '0;
        bus.data_valid_in = 1'b0;
        do_reset();
        check_idle_outputs("reset");

        // 1: single word A5 with receiver always ready
        st = 1'b1;
        s0 = strobes; a0 = acks;
        bus.data_in = 8'hA5; bus.data_valid_in = 1'b1; exp_q.push_back(8'hA5);
        step();
        chk("t1_ack", int'(bus.data_ack_out), 1);
        chk("t1_busy", int'(bus.busy_out), 1);
        bus.data_valid_in = 1'b0;
        wait_done("t1_done");
        chk("t1_strobes", strobes - s0, 8);
        step();
        chk("t1_busy_low", int'(bus.busy_out), 0);
        chk("t1_acks", acks - a0, 1);

        // 2: pause after third bit of C3
        s0 = strobes;
        bus.data_in = 8'hC3; bus.data_valid_in = 1'b1; exp_q.push_back(8'hC3);
        wait_ack("t2_ack");
        bus.data_valid_in = 1'b0;
        repeat (3) begin
            step();
            chk("t2_wr_pre", int'(bus.write_out), 1);
        end
        st = 1'b0;
        repeat (3) begin
            step();
            chk("t2_wr_pause", int'(bus.write_out), 0);
            chk("t2_dout_hold", int'(bus.data_out), 0);
        end
        st = 1'b1;
        wait_done("t2_done");
        chk("t2_strobes", strobes - s0, 8);

        // 3: back-to-back 01, FF with valid held
        s0 = strobes; a0 = acks;
        bus.data_in = 8'h01; bus.data_valid_in = 1'b1;
        exp_q.push_back(8'h01); exp_q.push_back(8'hFF);
        wait_ack("t3_ack0");
        bus.data_in = 8'hFF;
        wait_ack("t3_ack1");
        bus.data_valid_in = 1'b0;
        wait_done("t3_done1");
        chk("t3_acks", acks - a0, 2);
        chk("t3_strobes", strobes - s0, 16);

        // 4: reset in the middle of 5A
        bus.data_in = 8'h5A; bus.data_valid_in = 1'b1;
        wait_ack("t4_ack");
        bus.data_valid_in = 1'b0;
        repeat (4) step();
        chk("t4_wr_mid", int'(bus.write_out), 1);
        reset = 1'b1;
        #1;
        check_idle_outputs("t4_abort");
        s0 = strobes;
        repeat (3) step();
        chk("t4_no_strobes", strobes - s0, 0);
        bus.data_in = 8'h5A; bus.data_valid_in = 1'b1; exp_q.push_back(8'h5A);
        reset = 1'b0;
        s0 = strobes; a0 = acks;
        wait_ack("t4_reload_ack");
        bus.data_valid_in = 1'b0;
        wait_done("t4_done");
        chk("t4_strobes", strobes - s0, 8);
        chk("t4_acks", acks - a0, 1);

        // 5: loopback into receiver model
        rx_en = 1'b1;
        foreach (exp_rx[i]) exp_rx.delete(i);
        for (int k = 0; k < 3; k++) begin
            logic [DW-1:0] w;
            w = (k == 0) ? 8'h3C : (k == 1) ? 8'h96 : 8'h00;
            exp_q.push_back(w); exp_rx.push_back(w);
            bus.data_in = w; bus.data_valid_in = 1'b1;
            wait_ack("t5_ack");
            bus.data_valid_in = 1'b0;
            wait_done("t5_done");
        end
        repeat (4) step();
        chk("t5_rx_left", exp_rx.size(), 0);
        rx_en = 1'b0;

        // 6: word loads while receiver not ready from reset
        st = 1'b0;
        do_reset();
        s0 = strobes;
        bus.data_in = 8'h69; bus.data_valid_in = 1'b1; exp_q.push_back(8'h69);
        wait_ack("t6_ack");
        bus.data_valid_in = 1'b0;
        repeat (5) step();
        chk("t6_no_strobes", strobes - s0, 0);
        chk("t6_busy", int'(bus.busy_out), 1);
        st = 1'b1;
        wait_done("t6_done");
        chk("t6_strobes", strobes - s0, 8);

        repeat (3) step();
        chk("exp_q_left", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
